alu_core: RTL and testbench

ALU_CORE -- requirements
Module: alu_core

---
 rtl/alu_if.sv | 29 ++
 rtl/alu_core.sv | 161 ++++++++++++++++
 tb/tb_alu_core.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_if.sv
// ALU operation/result bus. The core is the slave; the operand source is the master.
//
// Handshake: an operation (A, B, Opcode) transfers on a rising clk edge where
// in_valid=1 and in_ready=1. An in_valid seen while in_ready=0 is dropped, not
// held or queued. Each result appears with a one-cycle out_valid pulse that has
// no back-pressure. Result and Error hold their values until the next pulse.
interface alu_if #(
  parameter int WIDTH = 32
) ();
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [2:0]       Opcode;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] Result;
  logic             Error;
  logic             out_valid;
  logic             dbg_state;  // 1 while the divider FSM is in DIV_BUSY

  modport master (
    output A, B, Opcode, in_valid,
    input  in_ready, Result, Error, out_valid, dbg_state
  );

  modport slave (
    input  A, B, Opcode, in_valid,
    output in_ready, Result, Error, out_valid, dbg_state
  );
endinterface

// File: rtl/alu_core.sv
// Single-issue ALU. Non-DIV operations and DIV special cases take one extra
// cycle: operands are captured at accept, and the result is registered on the
// next edge. A regular DIV runs a restoring divider for WIDTH cycles on operand
// magnitudes. The core fixes the sign afterwards.
module alu_core #(
  parameter int WIDTH = 32
) (
  input  logic clk,
  input  logic rst,
  alu_if.slave bus
);
  localparam int SW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_OR = 3'd3,
                         OP_XOR = 3'd4, OP_SLL = 3'd5, OP_MUL = 3'd6, OP_DIV = 3'd7;

  typedef enum logic {IDLE = 1'b0, DIV_BUSY = 1'b1} state_t;

  state_t state, state_nxt;
  logic run;
  logic accept, div_special, start_div, last_iter;
  logic [WIDTH-1:0] a_q, b_q;
  logic [2:0] op_q;
  logic pend, div_done, neg_q;
  logic [WIDTH-1:0] rem, quo, dvsr, rem_nxt, quo_nxt;
  logic [WIDTH:0] trial, trial_sub;
  logic [SW-1:0] cnt;
  logic [WIDTH-1:0] sum, diff, alu_res, quot_signed;
  logic [2*WIDTH-1:0] prod;
  logic alu_err;

  // Reset release is retimed by one flop so that the first accept happens on the second edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) run <= 1'b0;
    else      run <= 1'b1;
  end

  assign accept      = bus.in_valid && (state == IDLE) && run;
  assign div_special = (bus.B == '0) || ((bus.A == MIN_VAL) && (bus.B == '1));
  assign start_div   = accept && (bus.Opcode == OP_DIV) && !div_special;
  assign last_iter   = (state == DIV_BUSY) && (cnt == SW'(WIDTH - 1));

  assign bus.in_ready  = (state == IDLE);
  assign bus.dbg_state = (state == DIV_BUSY);

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // FSM next state: only a regular DIV leaves IDLE, and it returns after WIDTH iterations
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (start_div) state_nxt = DIV_BUSY;
      DIV_BUSY: if (last_iter) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Operand capture for single-cycle operations; pend marks a result due on the next edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q  <= '0;
      b_q  <= '0;
      op_q <= OP_ADD;
      pend <= 1'b0;
    end else begin
      pend <= accept && !start_div;
      if (accept) begin
        a_q  <= bus.A;
        b_q  <= bus.B;
        op_q <= bus.Opcode;
      end
    end
  end

  // One restoring step: shift the next dividend bit into the remainder, then subtract if it fits
  assign trial     = {rem, quo[WIDTH-1]};
  assign trial_sub = trial - {1'b0, dvsr};
  assign rem_nxt   = trial_sub[WIDTH] ? trial[WIDTH-1:0] : trial_sub[WIDTH-1:0];
  assign quo_nxt   = {quo[WIDTH-2:0], ~trial_sub[WIDTH]};

  // Divider datapath: magnitudes are loaded at accept and iterated once per busy cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rem      <= '0;
      quo      <= '0;
      dvsr     <= '0;
      cnt      <= '0;
      neg_q    <= 1'b0;
      div_done <= 1'b0;
    end else begin
      div_done <= last_iter;
      if (start_div) begin
        rem   <= '0;
        quo   <= bus.A[WIDTH-1] ? -bus.A : bus.A;
        dvsr  <= bus.B[WIDTH-1] ? -bus.B : bus.B;
        cnt   <= '0;
        neg_q <= bus.A[WIDTH-1] ^ bus.B[WIDTH-1];
      end else if (state == DIV_BUSY) begin
        rem <= rem_nxt;
        quo <= quo_nxt;
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign quot_signed = neg_q ? -quo : quo;
  assign sum  = a_q + b_q;
  assign diff = a_q - b_q;
  assign prod = {{WIDTH{a_q[WIDTH-1]}}, a_q} * {{WIDTH{b_q[WIDTH-1]}}, b_q};

  // Single-cycle result and error flag; DIV reaches this path only as a special case
  always_comb begin
    alu_res = '0;
    alu_err = 1'b0;
    case (op_q)
      OP_ADD: begin
        alu_res = sum;
        alu_err = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff;
        alu_err = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_AND: alu_res = a_q & b_q;
      OP_OR:  alu_res = a_q | b_q;
      OP_XOR: alu_res = a_q ^ b_q;
      OP_SLL: alu_res = a_q << b_q[SW-1:0];
      OP_MUL: begin
        alu_res = prod[WIDTH-1:0];
        alu_err = !((&prod[2*WIDTH-1:WIDTH-1]) || !(|prod[2*WIDTH-1:WIDTH-1]));
      end
      OP_DIV: begin
        alu_res = (b_q == '0) ? '1 : MIN_VAL;
        alu_err = 1'b1;
      end
      default: ;
    endcase
  end

  // Output registers: Result/Error load only alongside an out_valid pulse and hold otherwise
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.Result    <= '0;
      bus.Error     <= 1'b0;
      bus.out_valid <= 1'b0;
    end else begin
      bus.out_valid <= pend || div_done;
      if (pend) begin
        bus.Result <= alu_res;
        bus.Error  <= alu_err;
      end else if (div_done) begin
        bus.Result <= quot_signed;
        bus.Error  <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_alu_core.sv
// Directed and random bench for alu_core (WIDTH=32) with an expected-result queue.
module tb_alu_core;
  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  logic [32:0] exp_q[$];
  int          cyc_q[$];
  logic [32:0] mon_e;
  int          mon_c;

  alu_if #(.WIDTH(32)) bus ();

  alu_core #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock and cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input logic [63:0] obs, input logic [63:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // reference model: {error, result}
  function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic [2:0] op);
    longint w;
    logic [31:0] r;
    logic e;
    w = 0; r = 0; e = 1'b0;
    case (op)
      3'd0: begin w = longint'($signed(a)) + longint'($signed(b)); r = w[31:0];
                  e = (w > 64'sd2147483647) || (w < -64'sd2147483648); end
      3'd1: begin w = longint'($signed(a)) - longint'($signed(b)); r = w[31:0];
                  e = (w > 64'sd2147483647) || (w < -64'sd2147483648); end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = a << b[4:0];
      3'd6: begin w = longint'($signed(a)) * longint'($signed(b)); r = w[31:0];
                  e = (w > 64'sd2147483647) || (w < -64'sd2147483648); end
      default: begin
        if (b == 32'h0) begin r = 32'hFFFFFFFF; e = 1'b1; end
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin r = 32'h80000000; e = 1'b1; end
        else r = $signed(a) / $signed(b);
      end
    endcase
    return {e, r};
  endfunction

  // driver: present one op at a negedge, it is accepted at the following posedge
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                      input logic [31:0] er, input logic ee, input int lat);
    @(negedge clk);
    bus.A = a; bus.B = b; bus.Opcode = op; bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    exp_q.push_back({ee, er});
    cyc_q.push_back(cyc + lat);
  endtask

  task automatic send_model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    logic [32:0] m;
    int lat;
    m = model(a, b, op);
    lat = (op == 3'd7 && m[32] == 1'b0) ? 33 : 1;
    send(a, b, op, m[31:0], m[32], lat);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic drain(input int max);
    int n;
    n = 0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    while (exp_q.size() != 0 && n < max) begin
      @(negedge clk);
      n++;
    end
    chk(64'(exp_q.size()), 64'd0, "drain_timeout");
  endtask

  // scoreboard: compare every out_valid pulse with the oldest expectation
  always @(negedge clk) begin
    if (bus.out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk(64'(bus.out_valid), 64'd0, "spurious_out_valid");
      end else begin
        mon_e = exp_q.pop_front();
        mon_c = cyc_q.pop_front();
        chk(64'(bus.Result), 64'(mon_e[31:0]), "result");
        chk(64'(bus.Error), 64'(mon_e[32]), "error");
        chk(64'(cyc), 64'(mon_c), "latency");
      end
    end
  end

  initial begin
    int busy_cnt;
    logic [31:0] ra, rb;
    rst = 1'b0;
    bus.A = '0; bus.B = '0; bus.Opcode = 3'd0; bus.in_valid = 1'b0;

    // power-up reset values
    repeat (3) @(negedge clk);
    chk(64'(bus.Result), 64'd0, "rst_result");
    chk(64'(bus.Error), 64'd0, "rst_error");
    chk(64'(bus.out_valid), 64'd0, "rst_out_valid");
    chk(64'(bus.in_ready), 64'd1, "rst_in_ready");

    // release; an op offered on the first edge after release must be ignored
    rst = 1'b1;
    bus.A = 32'h7FFFFFFF; bus.B = 32'h1; bus.Opcode = 3'd0; bus.in_valid = 1'b1;
    send(32'h7FFFFFFF, 32'h1, 3'd0, 32'h80000000, 1'b1, 1);
    drain(10);

    // Result/Error hold between pulses
    idle(3);
    chk(64'(bus.Result), 64'h80000000, "hold_result");
    chk(64'(bus.Error), 64'd1, "hold_error");
    chk(64'(bus.out_valid), 64'd0, "hold_out_valid");

    // back-to-back AND, SLL, SUB
    send(32'hF0F0F0F0, 32'hFF00FF00, 3'd2, 32'hF000F000, 1'b0, 1);
    send(32'h1, 32'd35, 3'd5, 32'h8, 1'b0, 1);
    send(32'd5, 32'd7, 3'd1, 32'hFFFFFFFE, 1'b0, 1);
    // MUL overflow, then the two DIV special cases back-to-back
    send(32'h00010000, 32'h00010000, 3'd6, 32'h0, 1'b1, 1);
    send(32'h00001234, 32'h0, 3'd7, 32'hFFFFFFFF, 1'b1, 1);
    send(32'h80000000, 32'hFFFFFFFF, 3'd7, 32'h80000000, 1'b1, 1);
    drain(10);

    // regular DIV: busy for 32 cycles, an op offered mid-busy is dropped
    send(32'hFFFFFFF9, 32'd2, 3'd7, 32'hFFFFFFFD, 1'b0, 33);
    busy_cnt = 0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (bus.in_ready === 1'b0) busy_cnt++;
      bus.in_valid = (i == 5);
      bus.A = 32'd100 + 32'(i); bus.B = 32'd9; bus.Opcode = 3'd0;
    end
    chk(64'(busy_cnt), 64'd32, "div_busy_cycles");
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk(64'(bus.in_ready), 64'd1, "div_ready_again");
    drain(40);

    // random back-to-back single-cycle ops
    for (int i = 0; i < 12; i++) begin
      ra = $urandom;
      rb = (i % 3 == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      send_model(ra, rb, 3'($urandom_range(0, 6)));
    end
    drain(20);

    // random divisions, including small and negative operands
    for (int i = 0; i < 4; i++) begin
      ra = (i % 2 == 0) ? $urandom : 32'($urandom_range(0, 1000)) - 32'd500;
      rb = (i == 3) ? 32'($urandom_range(1, 9)) : $urandom;
      send_model(ra, rb, 3'd7);
      drain(40);
    end

    // reset 10 cycles into a DIV: aborted, outputs cleared
    send(32'd1000, 32'd3, 3'd7, 32'd333, 1'b0, 33);
    idle(10);
    rst = 1'b0;
    exp_q.delete();
    cyc_q.delete();
    #1;
    chk(64'(bus.Result), 64'd0, "abort_result");
    chk(64'(bus.Error), 64'd0, "abort_error");
    chk(64'(bus.out_valid), 64'd0, "abort_out_valid");
    chk(64'(bus.in_ready), 64'd1, "abort_in_ready");
    chk(64'(bus.dbg_state), 64'd0, "abort_state");
    repeat (3) @(negedge clk);
    rst = 1'b1;
    bus.A = 32'd2; bus.B = 32'd3; bus.Opcode = 3'd0; bus.in_valid = 1'b1;
    send(32'd2, 32'd3, 3'd0, 32'd5, 1'b0, 1);
    drain(10);
    // no late pulse from the aborted division
    idle(40);
    chk(64'(exp_q.size()), 64'd0, "final_queue");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
